parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
//  Serial receive/check stage downstream of the serial parity generator.
//  Consumes a 1-bit-per-strobe frame: start(0), DATA_W data bits LSB-first,
//  one parity bit, stop(1). Deserialises the data word, checks parity and
//  stop bit, and presents the word plus error flags with a 1-cycle valid pulse.
// PARAMETERS
//  DATA_W      3   data bits per frame (>=1)
//  PARITY_ODD  0   0: data+parity must hold an even count of 1s; 1: odd count
// PORTS
//  i_clk      in   1       system clock, rising edge
//  i_rst      in   1       asynchronous, active-low reset
//  i_x        in   1       serial line, idle high
//  i_bit_en   in   1       bit strobe; i_x sampled only on edges where high
//  o_data     out  DATA_W  last received word (bit 0 = first data bit)
//  o_valid    out  1       1-cycle pulse: o_data/o_par_err/o_frm_err updated
//  o_par_err  out  1       parity mismatch on last frame
//  o_frm_err  out  1       stop bit sampled as 0 on last frame
//  o_busy     out  1       high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (i_rst=0, asynchronous): state=IDLE, bit counter=0, shift reg=0,
//   running parity=0; o_data=0, o_valid=0, o_par_err=0, o_frm_err=0, o_busy=0.
//   Reset mid-frame aborts the frame; no o_valid is produced for it.
//  All state changes occur only on edges with i_bit_en=1, except o_valid clear.
//  FSM:
//   IDLE : i_x=0 sampled -> DATA, cnt=0, par=PARITY_ODD; i_x=1 -> stay.
//   DATA : shift i_x in at MSB (shift right), par ^= i_x, cnt++;
//          after DATA_W-th bit (cnt==DATA_W-1) -> PAR.
//   PAR  : par ^= i_x -> STOP.
//   STOP : o_data<=shift reg, o_par_err<=par, o_frm_err<=~i_x,
//          o_valid<=1 -> IDLE.
//  Even mode: o_par_err = XOR(data bits, parity bit); odd mode: inverted.
//  o_valid high for exactly one i_clk cycle after the stop-sample edge,
//   regardless of i_bit_en on the following edge.
//  o_data and error flags hold their value until the next frame completes.
//  Errored frames are still delivered (o_valid=1); consumer decides to drop.
//  Framing error does not resync: next IDLE sample of 0 starts a new frame.
//  Back-to-back frames: start bit may be sampled on the strobe immediately
//   after the stop bit; no idle gap required.
//  i_bit_en held low: block holds state indefinitely.
//  i_bit_en tied high: one bit per clock; frame length = DATA_W+3 strobes.
//  o_busy is combinational from state (IDLE -> 0).
//  Counter width clog2(DATA_W) (min 1); no wrap beyond DATA_W-1.
// TESTING (DATA_W=3, PARITY_ODD=0 unless stated)
//  1 Line bits 0,1,0,1,0,1 (start, d=1,0,1, par 0, stop 1), i_bit_en=1
//    -> o_valid pulse 1 cycle, o_data=3'b101, o_par_err=0, o_frm_err=0.
//  2 Same frame with parity bit 1 -> o_data=3'b101, o_par_err=1, o_frm_err=0.
//  3 Frame d=1,1,0, par 0, stop 0 -> o_data=3'b011, o_par_err=0, o_frm_err=1.
//  4 i_rst pulsed low after 2nd data bit, then clean frame d=1,1,1,par 1,stop 1
//    -> no valid for aborted frame; then o_data=3'b111, errors 0.
//  5 i_bit_en high every 3rd clock, two back-to-back frames (101 then 010)
//    -> two o_valid pulses, each 1 clock wide; o_data 101 then 010, no errors.
//  6 PARITY_ODD=1, frame d=0,0,0, par 1, stop 1 -> o_data=0, o_par_err=0;
//    same frame with par 0 -> o_par_err=1.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Delivers the word with parity/framing error flags and a one-cycle valid pulse.
module parity_frame_checker #(
   parameter int DATA_W     = 3,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_x,
   input  logic              i_bit_en,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_par_err,
   output logic              o_frm_err,
   output logic              o_busy,
   output logic [1:0]        o_state
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] shift;
   logic [DATA_W:0]   shift_ext;
   logic              par;
   logic              last_bit;

   assign last_bit  = (cnt == CW'(DATA_W - 1));
   // New bit enters at the MSB so the first data bit ends up at bit 0.
   assign shift_ext = {i_x, shift};
   assign o_busy    = (state != IDLE);
   assign o_state   = state;

   always_comb begin
      state_nxt = state;
      if (i_bit_en) begin
         case (state)
            IDLE: if (!i_x) state_nxt = DATA;
            DATA: if (last_bit) state_nxt = PAR;
            PAR:  state_nxt = STOP;
            STOP: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt       <= '0;
         shift     <= '0;
         par       <= 1'b0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_par_err <= 1'b0;
         o_frm_err <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_bit_en) begin
            case (state)
               IDLE: begin
                  if (!i_x) begin
                     cnt <= '0;
                     par <= PARITY_ODD;
                  end
               end
               DATA: begin
                  shift <= shift_ext[DATA_W:1];
                  par   <= par ^ i_x;
                  if (!last_bit) cnt <= cnt + CW'(1);
               end
               PAR: par <= par ^ i_x;
               STOP: begin
                  // par seeded with PARITY_ODD, so nonzero here means a mismatch.
                  o_data    <= shift;
                  o_par_err <= par;
                  o_frm_err <= ~i_x;
                  o_valid   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: even and odd parity instances, each
// with its own expected-result queue drained by a monitor on o_valid.
module tb_parity_frame_checker;

   localparam int DW = 3;
   localparam int W  = DW + 2;   // {data, par_err, frm_err}

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic x = 1'b1;
   logic en = 1'b0;
   logic use_odd = 1'b0;
   logic en_e, en_o;

   logic [DW-1:0] data_e, data_o;
   logic valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
   logic [1:0] state_e, state_o;

   logic [W-1:0] exp_q_e[$];
   logic [W-1:0] exp_q_o[$];

   int checks = 0;
   int errors = 0;

   assign en_e = en & ~use_odd;
   assign en_o = en & use_odd;

   parity_frame_checker #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
      .i_clk(clk), .i_rst(rst_n), .i_x(x), .i_bit_en(en_e),
      .o_data(data_e), .o_valid(valid_e), .o_par_err(perr_e),
      .o_frm_err(ferr_e), .o_busy(busy_e), .o_state(state_e)
   );

   parity_frame_checker #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
      .i_clk(clk), .i_rst(rst_n), .i_x(x), .i_bit_en(en_o),
      .o_data(data_o), .o_valid(valid_o), .o_par_err(perr_o),
      .o_frm_err(ferr_o), .o_busy(busy_o), .o_state(state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1);
   end

   // scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && valid_e) begin
         checks++;
         if (exp_q_e.size() == 0) begin
            errors++;
            $display("FAIL even_unexpected_valid: got %b, required no valid", {data_e, perr_e, ferr_e});
         end else begin
            logic [W-1:0] exp_v;
            exp_v = exp_q_e.pop_front();
            if ({data_e, perr_e, ferr_e} !== exp_v) begin
               errors++;
               $display("FAIL even_frame: got %b, required %b", {data_e, perr_e, ferr_e}, exp_v);
            end
         end
      end
      if (rst_n && valid_o) begin
         checks++;
         if (exp_q_o.size() == 0) begin
            errors++;
            $display("FAIL odd_unexpected_valid: got %b, required no valid", {data_o, perr_o, ferr_o});
         end else begin
            logic [W-1:0] exp_v;
            exp_v = exp_q_o.pop_front();
            if ({data_o, perr_o, ferr_o} !== exp_v) begin
               errors++;
               $display("FAIL odd_frame: got %b, required %b", {data_o, perr_o, ferr_o}, exp_v);
            end
         end
      end
   end

   // driver tasks
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
      end
   endtask

   task automatic strobe_bit(input logic b, input int period);
      repeat (period - 1) begin
         en = 1'b0;
         @(posedge clk); #1;
      end
      en = 1'b1;
      x  = b;
      @(posedge clk); #1;
      en = 1'b0;
      x  = 1'b1;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int period);
      strobe_bit(1'b0, period);
      for (int i = 0; i < DW; i++) strobe_bit(d[i], period);
      strobe_bit(p, period);
      strobe_bit(s, period);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // stimulus
   initial begin
      rst_n = 1'b0;
      idle_cycles(3);
      chk("rst_data",    data_e,  0);
      chk("rst_valid",   valid_e, 0);
      chk("rst_par_err", perr_e,  0);
      chk("rst_frm_err", ferr_e,  0);
      chk("rst_busy",    busy_e,  0);
      chk("rst_state",   state_e, 0);
      rst_n = 1'b1;
      idle_cycles(2);

      // idle-high line keeps the block in IDLE
      strobe_bit(1'b1, 1);
      strobe_bit(1'b1, 1);
      chk("idle_busy", busy_e, 0);

      // clean frame d=1,0,1 par 0
      exp_q_e.push_back({3'b101, 1'b0, 1'b0});
      send_frame(3'b101, 1'b0, 1'b1, 1);
      idle_cycles(2);
      chk("hold_data", data_e, 3'b101);
      chk("hold_valid_low", valid_e, 0);

      // same frame, wrong parity
      exp_q_e.push_back({3'b101, 1'b1, 1'b0});
      send_frame(3'b101, 1'b1, 1'b1, 1);
      idle_cycles(2);

      // d=1,1,0 par 0, stop sampled 0
      exp_q_e.push_back({3'b011, 1'b0, 1'b1});
      send_frame(3'b011, 1'b0, 1'b0, 1);
      idle_cycles(2);

      // abort after second data bit
      strobe_bit(1'b0, 1);
      strobe_bit(1'b1, 1);
      strobe_bit(1'b1, 1);
      chk("mid_frame_busy", busy_e, 1);
      rst_n = 1'b0;
      #2;
      chk("abort_busy",  busy_e,  0);
      chk("abort_data",  data_e,  0);
      chk("abort_valid", valid_e, 0);
      rst_n = 1'b1;
      idle_cycles(2);
      exp_q_e.push_back({3'b111, 1'b0, 1'b0});
      send_frame(3'b111, 1'b1, 1'b1, 1);
      idle_cycles(2);

      // strobe every 3rd clock, back-to-back frames
      exp_q_e.push_back({3'b101, 1'b0, 1'b0});
      exp_q_e.push_back({3'b010, 1'b0, 1'b0});
      send_frame(3'b101, 1'b0, 1'b1, 3);
      send_frame(3'b010, 1'b1, 1'b1, 3);
      idle_cycles(4);

      // tied-high strobe, back-to-back frames with no idle gap
      exp_q_e.push_back({3'b110, 1'b0, 1'b0});
      exp_q_e.push_back({3'b001, 1'b1, 1'b0});
      send_frame(3'b110, 1'b0, 1'b1, 1);
      send_frame(3'b001, 1'b0, 1'b1, 1);
      idle_cycles(3);

      // odd parity instance
      use_odd = 1'b1;
      exp_q_o.push_back({3'b000, 1'b0, 1'b0});
      send_frame(3'b000, 1'b1, 1'b1, 1);
      idle_cycles(2);
      exp_q_o.push_back({3'b000, 1'b1, 1'b0});
      send_frame(3'b000, 1'b0, 1'b1, 1);
      idle_cycles(2);
      exp_q_o.push_back({3'b100, 1'b0, 1'b0});
      send_frame(3'b100, 1'b0, 1'b1, 2);
      idle_cycles(4);
      chk("even_held_while_odd", data_e, 3'b001);

      // final report
      chk("even_queue_drained", exp_q_e.size(), 0);
      chk("odd_queue_drained",  exp_q_o.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
